// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame transmitter.
package parity_pkg;

    // Width of one data byte on the producer side.
    localparam int DATA_W = 8;

    // Serial slots per frame: start, 8 data bits, parity, stop.
    localparam int FRAME_BITS = 11;

    // Width of the ones/zeros counters (must hold 0..8).
    localparam int COUNT_W = 4;

    // Width of the bit-period divider (BIT_DIV up to 255).
    localparam int DIV_W = 8;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Level driven on the serial line while in a given state.
    function automatic logic line_level(
        input state_t st,
        input logic   data_bit,
        input logic   par_bit
    );
        logic lvl;
        lvl = 1'b1;
        case (st)
            START:   lvl = 1'b0;
            DATA:    lvl = data_bit;
            PARITY:  lvl = par_bit;
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/byte_parity_unit.sv
// Combinational ones/zeros count and even-parity flag for one byte.
module byte_parity_unit
    import parity_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    output logic [COUNT_W-1:0] ones,
    output logic [COUNT_W-1:0] zeros,
    output logic               even_par
);

    // Running population count: stage gi holds the number of 1s in data[gi:0].
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_cnt
            logic [COUNT_W-1:0] psum;
            if (gi == 0) begin : g_first
                assign psum = COUNT_W'(data[0]);
            end else begin : g_rest
                assign psum = g_cnt[gi-1].psum + COUNT_W'(data[gi]);
            end
        end
    endgenerate

    assign ones     = g_cnt[DATA_W-1].psum;
    assign zeros    = COUNT_W'(DATA_W) - g_cnt[DATA_W-1].psum;

    // 1 when the byte holds an even number of 1s.
    assign even_par = ~^data;

endmodule

// File: rtl/parity_frame_tx.sv
// Byte-in, serial-frame-out controller: start, 8 data bits LSB first,
// even-ones parity flag, stop. Latches per-byte statistics and counts frames.
module parity_frame_tx #(
    parameter int DATA_W  = 8,
    parameter int BIT_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx_bit,
    output logic                          busy,
    output logic                          done,
    output logic                          parity_bit,
    output logic [parity_pkg::COUNT_W-1:0] ones_count,
    output logic [parity_pkg::COUNT_W-1:0] zeros_count,
    output logic [CNT_W-1:0]              frames_sent
);

    import parity_pkg::*;

    // Divider value on which the current serial slot ends.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    // Index of the last data bit in the frame.
    localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [2:0]           idx_reg, idx_next;
    logic [DATA_W-1:0]    shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic [COUNT_W-1:0]   ones_reg, ones_next;
    logic [COUNT_W-1:0]   zeros_reg, zeros_next;
    logic [CNT_W-1:0]     frames_reg, frames_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;

    logic                 capture;
    logic                 bit_end;
    logic [COUNT_W-1:0]   unit_ones;
    logic [COUNT_W-1:0]   unit_zeros;
    logic                 unit_even;

    // Statistics are computed on the live input byte and only kept at capture.
    byte_parity_unit u_parity (
        .data     (in_data),
        .ones     (unit_ones),
        .zeros    (unit_zeros),
        .even_par (unit_even)
    );

    assign in_ready = (state_reg == IDLE) && !rst;
    assign capture  = in_valid && in_ready;
    assign bit_end  = (div_reg == DIV_LAST);

    // Next-state logic: slot timing, bit stepping, capture and frame count.
    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        ones_next   = ones_reg;
        zeros_next  = zeros_reg;
        frames_next = frames_reg;

        if (state_reg == IDLE) begin
            div_next = '0;
            idx_next = '0;
            if (capture) begin
                shift_next  = in_data;
                parity_next = unit_even;
                ones_next   = unit_ones;
                zeros_next  = unit_zeros;
                state_next  = START;
            end
        end else if (bit_end) begin
            div_next = '0;
            case (state_reg)
                START: begin
                    state_next = DATA;
                end
                DATA: begin
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        state_next = PARITY;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[DATA_W-1:1]};
                    end
                end
                PARITY: begin
                    state_next = STOP;
                end
                STOP: begin
                    frames_next = frames_reg + CNT_W'(1);
                    state_next  = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else begin
            div_next = div_reg + DIV_W'(1);
        end
    end

    // Line level and done pulse are registered from the state about to be entered,
    // so the first slot appears on the cycle right after capture.
    always_comb begin
        tx_next   = line_level(state_next, shift_next[0], parity_next);
        done_next = (state_next == STOP) && (div_next == DIV_LAST);
    end

    // State and datapath registers with synchronous reset; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            div_reg    <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            ones_reg   <= '0;
            zeros_reg  <= '0;
            frames_reg <= '0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            ones_reg   <= ones_next;
            zeros_reg  <= zeros_next;
            frames_reg <= frames_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
        end
    end

    assign tx_bit      = tx_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign parity_bit  = parity_reg;
    assign ones_count  = ones_reg;
    assign zeros_count = zeros_reg;
    assign frames_sent = frames_reg;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed + randomized bench for parity_frame_tx: one instance at BIT_DIV=4,
// one at BIT_DIV=1 with a 4-bit frame counter so wrap-around is reachable.
module tb_parity_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    int          sel;

    logic        in_valid_a, in_valid_b;
    logic        a_ready, a_tx, a_busy, a_done, a_par;
    logic [3:0]  a_ones, a_zeros;
    logic [15:0] a_frames;
    logic        b_ready, b_tx, b_busy, b_done, b_par;
    logic [3:0]  b_ones, b_zeros;
    logic [3:0]  b_frames;

    logic        o_ready, o_tx, o_busy, o_done, o_par;
    logic [3:0]  o_ones, o_zeros;
    logic [15:0] o_frames;

    int tests;
    int fails;
    int cur_div;
    int cnt_mod;
    int frames_model;
    int exp_ones, exp_zeros, exp_par;

    always #5 clk = ~clk;

    assign in_valid_a = in_valid && (sel == 0);
    assign in_valid_b = in_valid && (sel == 1);

    parity_frame_tx #(.DATA_W(8), .BIT_DIV(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(a_ready), .tx_bit(a_tx), .busy(a_busy), .done(a_done),
        .parity_bit(a_par), .ones_count(a_ones), .zeros_count(a_zeros),
        .frames_sent(a_frames)
    );

    parity_frame_tx #(.DATA_W(8), .BIT_DIV(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(b_ready), .tx_bit(b_tx), .busy(b_busy), .done(b_done),
        .parity_bit(b_par), .ones_count(b_ones), .zeros_count(b_zeros),
        .frames_sent(b_frames)
    );

    // Route the instance under test to a common set of observation signals.
    always_comb begin
        if (sel == 0) begin
            o_ready = a_ready; o_tx = a_tx; o_busy = a_busy; o_done = a_done;
            o_par = a_par; o_ones = a_ones; o_zeros = a_zeros; o_frames = a_frames;
        end else begin
            o_ready = b_ready; o_tx = b_tx; o_busy = b_busy; o_done = b_done;
            o_par = b_par; o_ones = b_ones; o_zeros = b_zeros; o_frames = {12'h000, b_frames};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_ones"},   32'(o_ones),   32'(exp_ones));
        chk({tag, "_zeros"},  32'(o_zeros),  32'(exp_zeros));
        chk({tag, "_parity"}, 32'(o_par),    32'(exp_par));
        chk({tag, "_frames"}, 32'(o_frames), 32'(frames_model));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"},    32'(o_tx),    32'd1);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        check_stats(tag);
    endtask

    // Sends one byte starting from a negedge, checks the whole frame slot by slot
    // against the ideal waveform, and returns at the negedge of the following IDLE
    // cycle. keep_valid leaves in_valid high with nb for a back-to-back send;
    // abort_at>0 asserts reset on that frame cycle instead of finishing.
    task automatic send(input logic [7:0] b, input bit keep_valid,
                        input logic [7:0] nb, input int abort_at);
        bit slot [11];
        int n;
        int waited;
        int frame_len;
        n = $countones(b);
        slot[0] = 1'b0;
        for (int i = 0; i < 8; i++) slot[i+1] = b[i];
        slot[9]  = (n % 2 == 0);
        slot[10] = 1'b1;
        frame_len = 11 * cur_div;

        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (o_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_capture", 32'(o_ready), 32'd1);
        chk("idle_gap_extra_cycles", 32'(waited), 32'd0);
        @(posedge clk);
        exp_ones  = n;
        exp_zeros = 8 - n;
        exp_par   = (n % 2 == 0) ? 1 : 0;

        for (int k = 1; k <= frame_len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep_valid) begin
                    in_data = nb;
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
                check_stats("capture");
            end
            chk("tx_bit",  32'(o_tx),    32'(slot[(k-1)/cur_div]));
            chk("busy",    32'(o_busy),  32'd1);
            chk("ready",   32'(o_ready), 32'd0);
            chk("done",    32'(o_done),  32'(k == frame_len));
            if (k == frame_len) chk("frames_in_done", 32'(o_frames), 32'(frames_model));
            if (k == abort_at) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                frames_model = 0;
                exp_ones = 0; exp_zeros = 0; exp_par = 0;
                chk("abort_tx",    32'(o_tx),    32'd1);
                chk("abort_busy",  32'(o_busy),  32'd0);
                chk("abort_done",  32'(o_done),  32'd0);
                chk("abort_ready", 32'(o_ready), 32'd0);
                check_stats("abort");
                rst = 1'b0;
                @(negedge clk);
                check_idle("after_abort");
                return;
            end
        end
        frames_model = (frames_model + 1) % cnt_mod;
        @(negedge clk);
        check_idle("post_frame");
    endtask

    // Safety net: never hang if the design stalls.
    initial begin
        #400000;
        $display("FAIL watchdog: observed still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        bit keep;
        logic [7:0] nxt;

        tests = 0; fails = 0;
        sel = 0; cur_div = 4; cnt_mod = 65536; frames_model = 0;
        exp_ones = 0; exp_zeros = 0; exp_par = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;

        // Reset values and in_ready low while reset is held.
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(o_ready), 32'd0);
        chk("reset_tx",    32'(o_tx),    32'd1);
        chk("reset_busy",  32'(o_busy),  32'd0);
        chk("reset_done",  32'(o_done),  32'd0);
        check_stats("reset");
        rst = 1'b0;

        // Idle line for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Directed frames at BIT_DIV=4.
        send(8'hAD, 1'b0, 8'h00, 0);
        send(8'hFF, 1'b1, 8'h00, 0);
        send(8'h00, 1'b0, 8'h00, 0);

        // Random bytes, randomly back-to-back.
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) begin
            keep = (i < 5) && ($urandom_range(0, 1) == 1);
            nxt  = (i < 5) ? q[i+1] : 8'h00;
            send(q[i], keep, nxt, 0);
        end

        // Reset during DATA bit 3 of 0x5A (frame cycles 17..20), then one clean frame.
        send(8'h5A, 1'b0, 8'h00, 18);
        send(8'h3C, 1'b0, 8'h00, 0);

        // Second instance: one-cycle bits and a 4-bit frame counter.
        sel = 1; cur_div = 1; cnt_mod = 16; frames_model = 0;
        exp_ones = 0; exp_zeros = 0; exp_par = 0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("b_idle");
        send(8'h01, 1'b0, 8'h00, 0);

        // 16 more frames wrap the counter 15 -> 0.
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        for (int i = 0; i < 16; i++) begin
            keep = (i < 15) && ($urandom_range(0, 1) == 1);
            nxt  = (i < 15) ? q[i+1] : 8'h00;
            send(q[i], keep, nxt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Sequencing controller around the 8-bit parity/ones-count datapath. It accepts a byte over a valid/ready handshake and latches the parity bit (1 when the byte has an even number of 1s) and the 1s/0s counts. It then serialises a frame on a single line: start bit, 8 data bits LSB-first, parity bit, stop bit. It sits between a byte producer and a serial link, and exposes per-byte statistics plus a frame counter.

Parameters:
DATA_W, 8, data byte width; fixed at 8, other values unsupported.
BIT_DIV, 4, clock cycles per serial bit; legal range 1..255.
CNT_W, 16, width of frames_sent counter.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_data  in  8  byte to transmit
in_valid  in  1  producer has a byte
in_ready  out  1  controller can accept a byte (combinational: state==IDLE and !rst)
tx_bit  out  1  serial line, registered, idle-high
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in final cycle of STOP
parity_bit  out  1  latched parity: ~^byte
ones_count  out  4  latched number of 1s in byte (0..8)
zeros_count  out  4  latched number of 0s in byte (0..8)
frames_sent  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, tx_bit=1, busy=0, done=0, parity_bit=0, ones_count=0, zeros_count=0, frames_sent=0, bit index=0, divider=0. in_ready=0 while rst is high.
- Reset mid-frame: abort immediately. Next cycle follows the reset values above. No done pulse and no frames_sent increment.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: tx_bit=1. On in_valid & in_ready at an edge:
  - capture in_data into the shift register;
  - register parity_bit, ones_count, zeros_count from the sub-module, with ones_count+zeros_count=8 always;
  - go to START. Capture latency is one cycle.
- START: tx_bit=0 for BIT_DIV cycles.
- DATA: tx_bit=byte[idx] for BIT_DIV cycles each, idx 0..7. After idx 7 finishes, go to PARITY.
- PARITY: tx_bit=parity_bit for BIT_DIV cycles.
- STOP: tx_bit=1 for BIT_DIV cycles. In the last STOP cycle, assert done=1 and increment frames_sent (wrap 0xFFFF->0x0000). Next state is IDLE.
- Divider: counts 0..BIT_DIV-1. The state or bit advances when the divider equals BIT_DIV-1. With BIT_DIV=1, every bit lasts exactly one cycle.
- Frame length: 11*BIT_DIV cycles from the cycle after capture. At least one IDLE cycle separates frames, so maximum throughput is one byte per 11*BIT_DIV+1 cycles.
- in_data and in_valid are ignored outside IDLE. Changes to in_data mid-frame have no effect.
- Latched parity_bit and counts hold until the next capture, including through IDLE.

Decomposition:
- Shared package parity_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constant DATA_W=8;
  - constant FRAME_BITS=11;
  - count width constant 4.
- Sub-module byte_parity_unit: purely combinational.
  - Input: 8-bit byte.
  - Outputs: ones[3:0], zeros[3:0], even_par = ~^byte.
  - Instantiated once on in_data; its outputs are registered at capture.

Test Plan:
- Reset then idle, BIT_DIV=4: tx_bit=1, busy=0, in_ready=1, all counts 0, frames_sent=0 for 20 cycles.
- Send 0xAD, BIT_DIV=4 -> ones_count=5, zeros_count=3, parity_bit=0. tx_bit per 4-cycle slot is 0, then 1,0,1,1,0,1,0,1, then 0, then 1. done pulses at cycle 44 after capture and frames_sent=1.
- Send 0xFF, then 0x00 back-to-back with in_valid held high -> 0xFF gives ones=8, zeros=0, parity=1. 0x00 gives ones=0, zeros=8, parity=1. Exactly one IDLE cycle between frames and frames_sent=2.
- BIT_DIV=1, send 0x01 -> 11-cycle frame: 0, 1,0,0,0,0,0,0,0, 0, 1. done pulses on cycle 11.
- Assert rst during DATA bit 3 of 0x5A -> next cycle tx_bit=1, state IDLE, counts 0, frames_sent unchanged at 0, no done pulse.
- Preload frames_sent to 0xFFFF via 65535 frames (or force), send one byte -> frames_sent wraps to 0x0000 with done=1.
